// File: rtl/fir_mac_sequencer_pkg.sv
// Shared types and constants for the FIR MAC sequencer.
//   seq_state_t : sequencer states
//   LAT         : RAM read latency in cycles
//   clamp_taps  : maps a requested tap count onto 1..max_taps
// Macro FIR_SEQ_RAM_REG_EN selects RAMs with a registered output (LAT = 2);
// without it the RAMs are plain synchronous (LAT = 1).
package fir_pkg;

`ifdef FIR_SEQ_RAM_REG_EN
  localparam int unsigned LAT = 2;
`else
  localparam int unsigned LAT = 1;
`endif

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    LOAD,
    MAC,
    DRAIN,
    OUT,
    FIN
  } seq_state_t;

  function automatic int unsigned clamp_taps(input int unsigned taps,
                                             input int unsigned max_taps);
    if (taps == 0) return 1;
    if (taps > max_taps) return max_taps;
    return taps;
  endfunction

endpackage

// File: rtl/fir_mac_sequencer_if.sv
// Bus bundle between the FIR sequencer and its surroundings.
//   control : start, cfg_taps, cfg_num_samples -> ; <- busy, done, smp_cnt
//   input   : s_valid -> ; <- s_ready
//   RAMs    : <- smp_we, smp_waddr, rd_en, smp_raddr, coef_raddr
//   MAC     : <- acc_clr, acc_en
//   output  : <- y_valid ; y_ready ->
// slave is the sequencer side, master the side driving it.
interface fir_mac_sequencer_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 16
);
  logic              start;
  logic [ADDR_W:0]   cfg_taps;
  logic [CNT_W-1:0]  cfg_num_samples;
  logic              busy;
  logic              done;
  logic              s_valid;
  logic              s_ready;
  logic              smp_we;
  logic [ADDR_W-1:0] smp_waddr;
  logic              rd_en;
  logic [ADDR_W-1:0] smp_raddr;
  logic [ADDR_W-1:0] coef_raddr;
  logic              acc_clr;
  logic              acc_en;
  logic              y_valid;
  logic              y_ready;
  logic [CNT_W-1:0]  smp_cnt;

  modport slave (
    input  start, cfg_taps, cfg_num_samples, s_valid, y_ready,
    output busy, done, s_ready, smp_we, smp_waddr, rd_en, smp_raddr,
           coef_raddr, acc_clr, acc_en, y_valid, smp_cnt
  );

  modport master (
    output start, cfg_taps, cfg_num_samples, s_valid, y_ready,
    input  busy, done, s_ready, smp_we, smp_waddr, rd_en, smp_raddr,
           coef_raddr, acc_clr, acc_en, y_valid, smp_cnt
  );
endinterface

// File: rtl/fir_mac_sequencer_rd_pipe.sv
// Delay line that re-times the RAM read strobe onto the accumulator.
//   clk, rst : clock, asynchronous active-high reset
//   rd_en    : read strobe issued this cycle
//   first    : this read belongs to tap 0
//   acc_en   : rd_en delayed by DEPTH cycles
//   acc_clr  : (rd_en && first) delayed by DEPTH cycles
// DEPTH follows LAT, which depends on FIR_SEQ_RAM_REG_EN.
module fir_rd_pipe
  import fir_pkg::*;
#(
  parameter int unsigned DEPTH = LAT
) (
  input  logic clk,
  input  logic rst,
  input  logic rd_en,
  input  logic first,
  output logic acc_en,
  output logic acc_clr
);

  logic [DEPTH-1:0] en_sr;
  logic [DEPTH-1:0] clr_sr;

  // Shift in at bit 0; the cast drops the oldest bit, which also covers DEPTH = 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_sr  <= '0;
      clr_sr <= '0;
    end else begin
      en_sr  <= DEPTH'({en_sr, rd_en});
      clr_sr <= DEPTH'({clr_sr, rd_en && first});
    end
  end

  assign acc_en  = en_sr[DEPTH-1];
  assign acc_clr = clr_sr[DEPTH-1];

endmodule

// File: rtl/fir_mac_sequencer.sv
// Sequencer for a RAM-based FIR with a single MAC unit. Each accepted input
// sample is written into a circular sample RAM, then N coefficient/sample
// read pairs are issued and the accumulator controls follow them after the
// RAM read latency. Finished outputs leave over y_valid/y_ready.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : fir_mac_sequencer_if.slave (control, sample input, RAM
//              addresses, accumulator controls, output handshake)
// Macro FIR_SEQ_RAM_REG_EN: registered-output RAMs, read latency 2 instead of 1.
module fir_mac_sequencer
  import fir_pkg::*;
#(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned MAX_TAPS = 2**ADDR_W,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  fir_mac_sequencer_if.slave  bus
);

  seq_state_t        state, state_nxt;
  logic [ADDR_W-1:0] wptr, base, k;
  logic [ADDR_W:0]   taps_q;
  logic [CNT_W-1:0]  num_q, cnt_q;
  logic [1:0]        drain_cnt;
  logic              k_last, drain_last;

  logic              busy_c, done_c, s_ready_c, smp_we_c, rd_en_c, first_c, y_valid_c;
  logic [ADDR_W-1:0] smp_waddr_c, smp_raddr_c, coef_raddr_c;

  assign k_last     = ({1'b0, k} == taps_q - 1'b1);
  assign drain_last = (drain_cnt == 2'(LAT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.start) state_nxt = CHECK;
      CHECK:   state_nxt = (cnt_q == num_q) ? FIN : LOAD;
      LOAD:    if (bus.s_valid) state_nxt = MAC;
      MAC:     if (k_last) state_nxt = DRAIN;
      DRAIN:   if (drain_last) state_nxt = OUT;
      OUT:     if (bus.y_ready) state_nxt = CHECK;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Addresses are forced to zero outside the states that own them.
  always_comb begin
    busy_c       = 1'b0;
    done_c       = 1'b0;
    s_ready_c    = 1'b0;
    smp_we_c     = 1'b0;
    smp_waddr_c  = '0;
    rd_en_c      = 1'b0;
    first_c      = 1'b0;
    smp_raddr_c  = '0;
    coef_raddr_c = '0;
    y_valid_c    = 1'b0;
    unique case (state)
      CHECK: busy_c = 1'b1;
      LOAD: begin
        busy_c      = 1'b1;
        s_ready_c   = 1'b1;
        smp_we_c    = bus.s_valid;
        smp_waddr_c = wptr;
      end
      MAC: begin
        busy_c       = 1'b1;
        rd_en_c      = 1'b1;
        first_c      = (k == '0);
        coef_raddr_c = k;
        smp_raddr_c  = base - k;
      end
      DRAIN: busy_c = 1'b1;
      OUT: begin
        busy_c    = 1'b1;
        y_valid_c = 1'b1;
      end
      FIN:     done_c = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr      <= '0;
      base      <= '0;
      k         <= '0;
      taps_q    <= '0;
      num_q     <= '0;
      cnt_q     <= '0;
      drain_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: if (bus.start) begin
          taps_q <= (ADDR_W+1)'(clamp_taps(32'(bus.cfg_taps), MAX_TAPS));
          num_q  <= bus.cfg_num_samples;
          cnt_q  <= '0;
        end
        LOAD: if (bus.s_valid) begin
          base <= wptr;
          wptr <= wptr + 1'b1;
          k    <= '0;
        end
        MAC: begin
          if (!k_last) k <= k + 1'b1;
          drain_cnt <= '0;
        end
        DRAIN: drain_cnt <= drain_cnt + 1'b1;
        OUT: if (bus.y_ready && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
        default: ;
      endcase
    end
  end

  fir_rd_pipe #(.DEPTH(LAT)) u_rd_pipe (
    .clk     (clk),
    .rst     (rst),
    .rd_en   (rd_en_c),
    .first   (first_c),
    .acc_en  (bus.acc_en),
    .acc_clr (bus.acc_clr)
  );

  assign bus.busy       = busy_c;
  assign bus.done       = done_c;
  assign bus.s_ready    = s_ready_c;
  assign bus.smp_we     = smp_we_c;
  assign bus.smp_waddr  = smp_waddr_c;
  assign bus.rd_en      = rd_en_c;
  assign bus.smp_raddr  = smp_raddr_c;
  assign bus.coef_raddr = coef_raddr_c;
  assign bus.y_valid    = y_valid_c;
  assign bus.smp_cnt    = cnt_q;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Scoreboard bench for fir_mac_sequencer. Stimulus tasks push the expected
// per-sample and per-run records; a negedge monitor matches them against
// what the DUT presents. Honours FIR_SEQ_RAM_REG_EN for the read latency.
module tb_fir_mac_sequencer;

  localparam int ADDR_W = 5;
  localparam int CNT_W  = 16;
`ifdef FIR_SEQ_RAM_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [ADDR_W-1:0] waddr;
    int                n;
    int                cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fir_mac_sequencer_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) sif ();

  fir_mac_sequencer #(.ADDR_W(ADDR_W), .MAX_TAPS(32), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  exp_t              exp_q[$];
  int                done_q[$];
  logic [ADDR_W-1:0] exp_wptr = '0;
  int                done_target = 0;
  int                done_cnt = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint outs();
    return longint'({sif.busy, sif.done, sif.s_ready, sif.smp_we, sif.smp_waddr,
                     sif.rd_en, sif.smp_raddr, sif.coef_raddr, sif.acc_clr,
                     sif.acc_en, sif.y_valid, sif.smp_cnt});
  endfunction

  // ---------------- monitor ----------------
  exp_t              cur;
  bit                active = 0, prev_yv = 0, prev_hs = 0, pend_inc = 0;
  int                t0 = 0, rdn = 0, enn = 0, clrn = 0, ref_cyc = 0, exp_after = 0;
  logic [ADDR_W-1:0] exp_ra;

  always @(negedge clk) begin
    if (rst) begin
      active = 0; prev_yv = 0; prev_hs = 0; pend_inc = 0;
    end else begin
      if (pend_inc) begin
        chk("smp_cnt_inc", sif.smp_cnt, exp_after);
        pend_inc = 0;
      end
      if (sif.start && !sif.busy && !sif.done) ref_cyc = cyc;
      if (sif.s_ready && exp_q.size() == 0) chk("unexp_s_ready", sif.s_ready, 0);
      if (sif.smp_we) begin
        chk("we_rd_excl", sif.rd_en, 0);
        if (exp_q.size() == 0) chk("unexp_smp_we", sif.smp_we, 0);
        else begin
          cur = exp_q.pop_front();
          active = 1; t0 = cyc; rdn = 0; enn = 0; clrn = 0;
          chk("smp_waddr", sif.smp_waddr, cur.waddr);
        end
      end
      if (sif.rd_en) begin
        if (!active) chk("unexp_rd_en", sif.rd_en, 0);
        else begin
          exp_ra = cur.waddr - ADDR_W'(rdn);
          chk("rd_cyc", cyc, t0 + 1 + rdn);
          chk("rd_within_n", longint'(rdn < cur.n), 1);
          chk("coef_raddr", sif.coef_raddr, rdn);
          chk("smp_raddr", sif.smp_raddr, exp_ra);
          rdn++;
        end
      end
      if (sif.acc_en) begin
        if (!active) chk("unexp_acc_en", sif.acc_en, 0);
        else begin
          chk("acc_en_cyc", cyc, t0 + 1 + LAT + enn);
          enn++;
        end
      end
      if (sif.acc_clr) begin
        chk("acc_clr_cyc", cyc, t0 + 1 + LAT);
        chk("acc_clr_with_en", sif.acc_en, 1);
        clrn++;
      end
      if (prev_yv && !prev_hs) chk("y_valid_held", sif.y_valid, 1);
      if (sif.y_valid && !prev_yv) begin
        if (!active) chk("unexp_y_valid", sif.y_valid, 0);
        else begin
          chk("y_valid_cyc", cyc, t0 + cur.n + LAT + 1);
          chk("rd_total", rdn, cur.n);
          chk("acc_en_total", enn, cur.n);
          chk("acc_clr_total", clrn, 1);
        end
      end
      if (sif.y_valid && !sif.y_ready && active) begin
        chk("bp_s_ready", sif.s_ready, 0);
        chk("bp_smp_cnt", sif.smp_cnt, cur.cnt);
      end
      if (sif.y_valid && sif.y_ready && active) begin
        chk("smp_cnt_at_out", sif.smp_cnt, cur.cnt);
        ref_cyc = cyc; pend_inc = 1; exp_after = cur.cnt + 1; active = 0;
      end
      if (sif.done) begin
        if (done_q.size() == 0) chk("unexp_done", sif.done, 0);
        else begin
          chk("done_final_cnt", sif.smp_cnt, done_q.pop_front());
          chk("done_delay", cyc - ref_cyc, 2);
          chk("done_not_busy", sif.busy, 0);
          done_cnt++;
        end
      end
      prev_yv = sif.y_valid;
      prev_hs = sif.y_valid && sif.y_ready;
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue_run(input int taps, input int n, input int nsamp);
    for (int i = 0; i < nsamp; i++) begin
      exp_q.push_back('{waddr: exp_wptr, n: n, cnt: i});
      exp_wptr = exp_wptr + 1'b1;
    end
    done_q.push_back(nsamp);
    done_target++;
    @(posedge clk); #1;
    sif.cfg_taps        = (ADDR_W+1)'(taps);
    sif.cfg_num_samples = CNT_W'(nsamp);
    sif.start           = 1'b1;
    @(posedge clk); #1;
    sif.start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_cnt < done_target; i++) @(posedge clk);
    chk("done_count", done_cnt, done_target);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc;
    int dc;
    sif.start = 1'b0; sif.cfg_taps = '0; sif.cfg_num_samples = '0;
    sif.s_valid = 1'b1; sif.y_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("reset_outputs", outs(), 0);
    rst = 1'b0;

    // N=4, one output, plus a start pulse while busy that must be ignored
    issue_run(4, 4, 1);
    sif.start = 1'b1; sif.cfg_taps = 6'd7; sif.cfg_num_samples = 16'd9;
    @(posedge clk); #1 sif.start = 1'b0;
    wait_done(100);

    // backpressure: y_ready low for 5 cycles on the first output
    sif.y_ready = 1'b0;
    issue_run(2, 2, 2);
    for (int i = 0; i < 100 && !sif.y_valid; i++) @(negedge clk);
    chk("bp_y_valid_seen", sif.y_valid, 1);
    repeat (5) @(posedge clk);
    #1 sif.y_ready = 1'b1;
    wait_done(100);

    // tap clamping
    issue_run(0, 1, 2);
    wait_done(100);
    issue_run(40, 32, 1);
    wait_done(200);

    // zero samples; start held during the done pulse is ignored
    issue_run(5, 5, 0);
    for (int i = 0; i < 20 && !sif.done; i++) @(negedge clk);
    sif.start = 1'b1;
    @(posedge clk); #1 sif.start = 1'b0;
    @(posedge clk); #1;
    chk("start_at_done_ignored", sif.busy, 0);
    wait_done(20);

    // reset while k = 2
    issue_run(4, 4, 1);
    rc = 0;
    for (int i = 0; i < 50 && rc < 3; i++) begin
      @(negedge clk);
      if (sif.rd_en) rc++;
    end
    chk("rst_reached_k2", rc, 3);
    #1 rst = 1'b1;
    #1 chk("rst_mid_outputs", outs(), 0);
    exp_q.delete(); done_q.delete(); done_target--;
    exp_wptr = '0;
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    dc = done_cnt;
    repeat (10) @(posedge clk);
    chk("no_done_after_rst", done_cnt, dc);
    chk("idle_after_rst", outs(), 0);
    issue_run(3, 3, 2);
    wait_done(100);

    // write-pointer wrap: 33 samples from wptr 0
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_wptr = '0;
    issue_run(3, 3, 33);
    wait_done(800);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
